// File: rtl/hdmi_data_island_packetizer.sv
// HDMI data-island sequencer: preamble, guard bands and packet nibbles for TMDS
// channels 0..2, with the BCH parity computed serially as the packet goes out.
module hdmi_data_island_packetizer #(
  parameter int MAX_PACKETS  = 18,
  parameter int MIN_CTRL     = 12,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hsync,
  input  logic         vsync,
  input  logic         pkt_valid,
  output logic         pkt_ready,
  input  logic [23:0]  pkt_header,
  input  logic [223:0] pkt_sub,
  output logic [1:0]   period,
  output logic [3:0]   ctl,
  output logic [3:0]   ch0_nib,
  output logic [3:0]   ch1_nib,
  output logic [3:0]   ch2_nib
);

  localparam logic [1:0] P_CTRL = 2'd0, P_PRE = 2'd1, P_GUARD = 2'd2, P_DATA = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGB, S_PKT, S_TGB, S_GAP} state_t;

  function automatic logic [7:0] bch_step(input logic [7:0] p, input logic b);
    logic fb;
    fb = b ^ p[0];
    return {1'b0, p[7:1]} ^ (fb ? 8'h83 : 8'h00);
  endfunction

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] gap_cnt;
  logic [4:0]  npk;
  logic        more;

  logic [23:0] hdr_buf;
  logic [55:0] sub_buf [4];
  logic [7:0]  hpar;
  logic [7:0]  spar [4];

  logic        load, enter_data, first_data;
  logic [4:0]  idx;
  logic [23:0] src_hdr;
  logic [55:0] src_sub [4];
  logic [7:0]  hpar_nxt;
  logic [7:0]  spar_nxt [4];
  logic [3:0]  d0, d1, d2;

  // Everything needed for the DATA cycle about to be registered: its index,
  // its source bits (straight from the input on the accept edge) and parity.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    load       = (state == S_LGB && cnt == 16'd1) || (state == S_PKT && cnt == 16'd31 && more);
    enter_data = load || (state == S_PKT && cnt != 16'd31);
    first_data = (state == S_LGB);
    idx        = load ? 5'd0 : cnt[4:0] + 5'd1;
    src_hdr    = load ? pkt_header : hdr_buf;
    hpar_nxt   = hpar;
    d0         = {~first_data, hpar[idx[2:0]], vsync, hsync};
    d1         = 4'd0;
    d2         = 4'd0;
    if (idx < 5'd24) begin
      hpar_nxt = bch_step((idx == 5'd0) ? 8'h00 : hpar, src_hdr[idx]);
      d0[2]    = src_hdr[idx];
    end
    for (int k = 0; k < 4; k++) begin
      src_sub[k]  = load ? pkt_sub[56*k +: 56] : sub_buf[k];
      spar_nxt[k] = spar[k];
      d1[k]       = spar[k][{idx[1:0], 1'b0}];
      d2[k]       = spar[k][{idx[1:0], 1'b1}];
      if (idx < 5'd28) begin
        spar_nxt[k] = bch_step(bch_step((idx == 5'd0) ? 8'h00 : spar[k],
                                        src_sub[k][{idx, 1'b0}]),
                               src_sub[k][{idx, 1'b1}]);
        d1[k] = src_sub[k][{idx, 1'b0}];
        d2[k] = src_sub[k][{idx, 1'b1}];
      end
    end
  end

  // NOTE: packet buffer and parity carry no reset; they are rewritten before use.
  always_ff @(posedge clk) begin
    if (enter_data) begin
      hpar <= hpar_nxt;
      for (int k = 0; k < 4; k++) spar[k] <= spar_nxt[k];
      if (load) begin
        hdr_buf <= pkt_header;
        for (int k = 0; k < 4; k++) sub_buf[k] <= pkt_sub[56*k +: 56];
      end
    end
  end

  // Outputs are registered for the cycle being entered, so each branch sets
  // both the next state and what that state drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gap_cnt   <= 16'(MIN_CTRL);
      npk       <= '0;
      more      <= 1'b0;
      pkt_ready <= 1'b0;
      period    <= P_CTRL;
      ctl       <= 4'd0;
      ch0_nib   <= 4'd0;
      ch1_nib   <= 4'd0;
      ch2_nib   <= 4'd0;
    end else begin
      // NOTE: non-blocking throughout; later assignments (DATA below) override defaults.
      pkt_ready <= 1'b0;
      period    <= P_CTRL;
      ctl       <= 4'd0;
      ch0_nib   <= 4'd0;
      ch1_nib   <= 4'd0;
      ch2_nib   <= 4'd0;
      case (state)
        S_IDLE: if (pkt_valid && gap_cnt >= 16'(MIN_CTRL)) begin
          state  <= S_PRE;
          cnt    <= '0;
          period <= P_PRE;
          ctl    <= 4'b0101;
        end
        S_PRE: if (cnt == 16'(PREAMBLE_LEN - 1)) begin
          state   <= S_LGB;
          cnt     <= '0;
          period  <= P_GUARD;
          ch0_nib <= {2'b11, vsync, hsync};
        end else begin
          cnt    <= cnt + 16'd1;
          period <= P_PRE;
          ctl    <= 4'b0101;
        end
        S_LGB: if (cnt == 16'd0) begin
          cnt       <= 16'd1;
          period    <= P_GUARD;
          ch0_nib   <= {2'b11, vsync, hsync};
          pkt_ready <= 1'b1;
        end else begin
          state <= S_PKT;
          cnt   <= '0;
          npk   <= 5'd1;
        end
        S_PKT: if (cnt == 16'd31) begin
          more <= 1'b0;
          cnt  <= '0;
          if (more) begin
            npk <= npk + 5'd1;
          end else begin
            state   <= S_TGB;
            period  <= P_GUARD;
            ch0_nib <= {2'b11, vsync, hsync};
          end
        end else begin
          cnt <= cnt + 16'd1;
          // Decide on cycle 30 so the accept strobe is visible during cycle 31.
          if (cnt == 16'd30 && pkt_valid && npk < 5'(MAX_PACKETS)) begin
            pkt_ready <= 1'b1;
            more      <= 1'b1;
          end
        end
        S_TGB: if (cnt == 16'd0) begin
          cnt     <= 16'd1;
          period  <= P_GUARD;
          ch0_nib <= {2'b11, vsync, hsync};
        end else begin
          state   <= S_GAP;
          gap_cnt <= 16'd1;
        end
        S_GAP: if (gap_cnt >= 16'(MIN_CTRL)) state <= S_IDLE;
               else gap_cnt <= gap_cnt + 16'd1;
        default: state <= S_IDLE;
      endcase
      if (enter_data) begin
        period  <= P_DATA;
        ch0_nib <= d0;
        ch1_nib <= d1;
        ch2_nib <= d2;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_data_island_packetizer.sv
// Scoreboard bench for hdmi_data_island_packetizer: directed packets, expected
// island cycles queued at issue time and compared by a free-running monitor.
module tb_hdmi_data_island_packetizer;

  localparam int MAXP = 3;
  localparam int MINC = 12;
  localparam int PRE  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         hsync = 1'b0;
  logic         vsync = 1'b0;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [23:0]  pkt_header;
  logic [223:0] pkt_sub;
  logic [1:0]   period;
  logic [3:0]   ctl, ch0_nib, ch1_nib, ch2_nib;

  hdmi_data_island_packetizer #(
    .MAX_PACKETS(MAXP), .MIN_CTRL(MINC), .PREAMBLE_LEN(PRE)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_header(pkt_header), .pkt_sub(pkt_sub),
    .period(period), .ctl(ctl),
    .ch0_nib(ch0_nib), .ch1_nib(ch1_nib), .ch2_nib(ch2_nib)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] period;
    logic [3:0] ctl;
    logic [3:0] ch0;
    logic [3:0] ch1;
    logic [3:0] ch2;
    logic       rdy;
  } rec_t;

  typedef struct packed {
    logic [23:0]  h;
    logic [223:0] s;
  } pkt_t;

  rec_t exp_q[$];
  pkt_t plist[8];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b1;
  logic hs_e = 1'b0, vs_e = 1'b0;
  int   ctrl_run = 0;
  int   last_gap = 0;
  int   sync_cyc = 0;
  rec_t got, e;

  function automatic logic [7:0] bch(input logic [55:0] v, input int n);
    logic [7:0] p;
    logic       fb;
    p = 8'h00;
    for (int j = 0; j < n; j++) begin
      fb = v[j] ^ p[0];
      p  = {1'b0, p[7:1]} ^ (fb ? 8'h83 : 8'h00);
    end
    return p;
  endfunction

  task automatic push(input logic [1:0] pd, input logic [3:0] c, input logic [3:0] c0,
                      input logic [3:0] c1, input logic [3:0] c2, input logic r);
    rec_t x;
    x.period = pd; x.ctl = c; x.ch0 = c0; x.ch1 = c1; x.ch2 = c2; x.rdy = r;
    exp_q.push_back(x);
  endtask

  // Expected island for packets plist[first .. first+n-1]; ch0[1:0] is filled by the monitor.
  task automatic push_island(input int first, input int n);
    pkt_t        pk;
    logic [7:0]  hp;
    logic [7:0]  sp [4];
    logic [55:0] sk;
    logic [3:0]  c0, c1, c2;
    for (int i = 0; i < PRE; i++) push(2'd1, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
    push(2'd2, 4'd0, 4'b1100, 4'd0, 4'd0, 1'b0);
    push(2'd2, 4'd0, 4'b1100, 4'd0, 4'd0, 1'b1);
    for (int p = 0; p < n; p++) begin
      pk = plist[first + p];
      hp = bch({32'd0, pk.h}, 24);
      for (int k = 0; k < 4; k++) begin
        sk    = pk.s[56*k +: 56];
        sp[k] = bch(sk, 56);
      end
      for (int i = 0; i < 32; i++) begin
        c0 = 4'd0;
        c0[3] = !(p == 0 && i == 0);
        if (i < 24) c0[2] = pk.h[i];
        else        c0[2] = hp[i-24];
        for (int k = 0; k < 4; k++) begin
          sk = pk.s[56*k +: 56];
          if (i < 28) begin
            c1[k] = sk[2*i];
            c2[k] = sk[2*i+1];
          end else begin
            c1[k] = sp[k][2*(i-28)];
            c2[k] = sp[k][2*(i-28)+1];
          end
        end
        push(2'd3, 4'd0, c0, c1, c2, (i == 31) && (p != n - 1));
      end
    end
    push(2'd2, 4'd0, 4'b1100, 4'd0, 4'd0, 1'b0);
    push(2'd2, 4'd0, 4'b1100, 4'd0, 4'd0, 1'b0);
  endtask

  // Sync inputs keep moving for the whole run; the monitor expects them one cycle late.
  initial forever begin
    @(posedge clk);
    #1;
    hsync = ~hsync;
    if (sync_cyc % 3 == 0) vsync = ~vsync;
    sync_cyc++;
  end

  always @(posedge clk) begin
    hs_e <= hsync;
    vs_e <= vsync;
  end

  initial forever begin
    @(negedge clk);
    if (period == 2'd0 && ctl == 4'd0) ctrl_run++;
    else begin
      if (period == 2'd1 && ctrl_run > 0) last_gap = ctrl_run;
      ctrl_run = 0;
    end
    if (mon_en && (period != 2'd0 || ctl != 4'd0 || pkt_ready)) begin
      got = {period, ctl, ch0_nib, ch1_nib, ch2_nib, pkt_ready};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output got=%h exp=none", got);
      end else begin
        e = exp_q.pop_front();
        if (e.period == 2'd2 || e.period == 2'd3) e.ch0[1:0] = {vs_e, hs_e};
        if (got !== e) begin
          fails++;
          $display("FAIL island_cycle at %0t got=%h exp=%h", $time, got, e);
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int c;
    c  = 0;
    ok = 1'b0;
    while (c < 400 && !ok) begin
      @(negedge clk);
      c++;
      if (pkt_ready) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout got=no pkt_ready exp=pkt_ready within 400 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int first, input int n);
    bit ok;
    ok = 1'b1;
    for (int p = 0; p < n && ok; p++) begin
      pkt_header = plist[first + p].h;
      pkt_sub    = plist[first + p].s;
      pkt_valid  = 1'b1;
      wait_ready(ok);
    end
    pkt_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got=%0d pending exp=0 pending", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int c;
    plist[0].h = 24'h000000; plist[0].s = '0;
    plist[1].h = 24'h000001; plist[1].s = '0;
    plist[2].h = 24'h000000; plist[2].s = 224'h1;
    plist[3].h = 24'hA5C30F;
    plist[3].s = {56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h00FF00FF00FF00, 56'h13579BDF02468A};
    plist[4].h = 24'h800000; plist[4].s = {4{56'h80000000000001}};
    plist[5].h = 24'h5A5A5A;
    plist[5].s = {56'hFFFFFFFFFFFFFF, 56'h0, 56'hAAAAAAAAAAAAAA, 56'h55555555555555};
    plist[6].h = 24'h0F0F0F; plist[6].s = {56'h1, 56'h2, 56'h4, 56'h8};
    plist[7].h = 24'h123456; plist[7].s = {4{56'h0011223344556677}};

    rst = 1'b1;
    pkt_valid = 1'b0;
    pkt_header = '0;
    pkt_sub = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({period, ctl, ch0_nib, ch1_nib, ch2_nib, pkt_ready} !== 19'd0) begin
      fails++;
      $display("FAIL reset_state got=%h exp=0", {period, ctl, ch0_nib, ch1_nib, ch2_nib, pkt_ready});
    end
    rst = 1'b0;

    // Null packet, single-bit header, single-bit subpacket 0.
    for (int t = 0; t < 3; t++) begin
      push_island(t, 1);
      send(t, 1);
      drain();
    end

    // Valid held for four packets: three fill one island, the fourth opens the next.
    push_island(3, MAXP);
    push_island(6, 1);
    send(3, 4);
    drain();
    tests++;
    if (last_gap < MINC || last_gap > MINC + 1) begin
      fails++;
      $display("FAIL inter_island_gap got=%0d exp=%0d..%0d", last_gap, MINC, MINC + 1);
    end

    // Reset on DATA cycle 10, then an immediate restart.
    mon_en = 1'b0;
    pkt_header = plist[7].h;
    pkt_sub    = plist[7].s;
    pkt_valid  = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (period != 2'd3 && c < 400);
    if (period != 2'd3) begin
      tests++;
      fails++;
      $display("FAIL data_start_timeout got=%0d exp=3", period);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({period, ctl, ch0_nib, ch1_nib, ch2_nib, pkt_ready} !== 19'd0) begin
      fails++;
      $display("FAIL reset_mid_island got=%h exp=0", {period, ctl, ch0_nib, ch1_nib, ch2_nib, pkt_ready});
    end
    exp_q.delete();
    push_island(7, 1);
    mon_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (period !== 2'd1 || ctl !== 4'd5) begin
      fails++;
      $display("FAIL restart_latency got=period %0d ctl %0d exp=period 1 ctl 5", period, ctl);
    end
    wait_ready(ok);
    pkt_valid = 1'b0;
    drain();

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
